// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-lane data memory: access sizes, FSM
// state encoding and a constant-evaluable log2 helper.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Smallest r with 2**r >= value; usable in parameter expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering for the data memory. The store side turns
// size/lane/data into a byte strobe plus replicated write data and flags
// misaligned or reserved accesses. The load side picks the addressed byte
// or half out of the raw word and sign- or zero-extends it.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_lane,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_strb,
  output logic [31:0] st_wdata_rep,
  output logic        st_misalign,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_lane,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  // Store side: strobe and lane replication; a misaligned access writes nothing.
  always_comb begin
    st_strb      = 4'b0000;
    st_wdata_rep = 32'h0;
    st_misalign  = 1'b0;
    case (st_size)
      SZ_BYTE: begin
        st_strb      = 4'b0001 << st_lane;
        st_wdata_rep = {4{st_wdata[7:0]}};
      end
      SZ_HALF: begin
        st_misalign  = st_lane[0];
        st_strb      = st_lane[1] ? 4'b1100 : 4'b0011;
        st_wdata_rep = {2{st_wdata[15:0]}};
      end
      SZ_WORD: begin
        st_misalign  = (st_lane != 2'b00);
        st_strb      = 4'b1111;
        st_wdata_rep = st_wdata;
      end
      default: begin
        st_misalign = 1'b1;
      end
    endcase
    if (st_misalign) begin
      st_strb = 4'b0000;
    end
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Load side: select the addressed lane(s) and extend to 32 bits.
  always_comb begin
    ld_byte = ld_raw[{ld_lane, 3'b000} +: 8];
    ld_half = ld_lane[1] ? ld_raw[31:16] : ld_raw[15:0];
    ld_data = 32'h0;
    case (ld_size)
      SZ_BYTE: ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
      SZ_WORD: ld_data = ld_raw;
      default: ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_mem_bytelane.sv
// Word-organised MEM-stage data memory with byte/half/word access, a
// registered single-cycle read, misalignment detection and an optional
// one-word-per-cycle zero sweep after reset. Each byte lane is its own
// array so the per-lane write enables map onto a plain RAM write port.
module data_mem_bytelane
  import dmem_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DEPTH_WORDS  = 512,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              rvalid_o,
  output logic [31:0]       rdata_o,
  output logic              misalign_o
);

  localparam int               IDX_W    = clog2(DEPTH_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH_WORDS - 1);

  state_t           state_reg, state_next;
  logic [IDX_W-1:0] clr_idx_reg, clr_idx_next;

  logic             clearing;
  logic             accept, st_acc, ld_acc;
  logic [IDX_W-1:0] req_idx, mem_idx;
  logic [ADDR_W-IDX_W-3:0] unused_addr_bits;

  logic [3:0]  st_strb;
  logic [31:0] st_wdata_rep;
  logic        acc_misalign;
  logic [3:0]  lane_we;
  logic [31:0] lane_wdata;
  logic [31:0] rd_raw;
  logic [31:0] ld_data;

  logic        rvalid_reg, misalign_reg;
  logic [1:0]  ld_size_reg, ld_lane_reg;
  logic        ld_unsigned_reg;

  // Upper address bits alias lower words, so they are deliberately dropped.
  assign unused_addr_bits = addr_i[ADDR_W-1:IDX_W+2];
  assign req_idx          = addr_i[IDX_W+1:2];

  assign ready_o  = (state_reg == ST_RUN);
  assign busy_o   = (state_reg == ST_INIT);
  assign clearing = (state_reg == ST_INIT) && !rst;
  assign accept   = req_i && ready_o && !rst;
  assign st_acc   = accept && we_i;
  assign ld_acc   = accept && !we_i;
  assign mem_idx  = clearing ? clr_idx_reg : req_idx;

  // State and sweep counter; reset restarts the sweep from word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= CLEAR_ON_RST ? ST_INIT : ST_RUN;
      clr_idx_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_idx_reg <= clr_idx_next;
    end
  end

  // Next-state: advance the sweep one word per cycle, leave INIT after the last word.
  always_comb begin
    state_next   = state_reg;
    clr_idx_next = clr_idx_reg;
    case (state_reg)
      ST_INIT: begin
        clr_idx_next = clr_idx_reg + 1'b1;
        if (clr_idx_reg == LAST_IDX) begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  dmem_lane_align u_align (
    .st_size      (size_i),
    .st_lane      (addr_i[1:0]),
    .st_wdata     (wdata_i),
    .st_strb      (st_strb),
    .st_wdata_rep (st_wdata_rep),
    .st_misalign  (acc_misalign),
    .ld_size      (ld_size_reg),
    .ld_lane      (ld_lane_reg),
    .ld_unsigned  (ld_unsigned_reg),
    .ld_raw       (rd_raw),
    .ld_data      (ld_data)
  );

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem [DEPTH_WORDS];
    logic [7:0] rd_byte_reg;

    assign lane_we[gi]          = clearing | (st_acc & ~acc_misalign & st_strb[gi]);
    assign lane_wdata[8*gi +: 8] = clearing ? 8'h00 : st_wdata_rep[8*gi +: 8];
    assign rd_raw[8*gi +: 8]     = rd_byte_reg;

    // Single-port lane RAM: sweep or store write, registered load read.
    always_ff @(posedge clk) begin
      if (lane_we[gi]) begin
        mem[mem_idx] <= lane_wdata[8*gi +: 8];
      end
      if (ld_acc) begin
        rd_byte_reg <= mem[mem_idx];
      end
    end
  end

  // Response registers plus the load attributes the extender needs a cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_reg      <= 1'b0;
      misalign_reg    <= 1'b0;
      ld_size_reg     <= SZ_WORD;
      ld_lane_reg     <= 2'b00;
      ld_unsigned_reg <= 1'b0;
    end else begin
      rvalid_reg   <= ld_acc;
      misalign_reg <= accept && acc_misalign;
      if (ld_acc) begin
        ld_size_reg     <= size_i;
        ld_lane_reg     <= addr_i[1:0];
        ld_unsigned_reg <= unsigned_i;
      end
    end
  end

  assign rvalid_o   = rvalid_reg;
  assign misalign_o = misalign_reg;
  assign rdata_o    = (rvalid_reg && !misalign_reg) ? ld_data : 32'h0;

endmodule

// File: tb/tb_data_mem_bytelane.sv
// Directed bench for data_mem_bytelane (16 words, clear-on-reset enabled).
// Inputs change on the falling edge; outputs are sampled on the falling edge
// following the accepting rising edge.
module tb_data_mem_bytelane;

  localparam logic [1:0] B = 2'b00;
  localparam logic [1:0] H = 2'b01;
  localparam logic [1:0] W = 2'b10;
  localparam logic [1:0] R = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i;
  logic        we_i;
  logic [1:0]  size_i;
  logic        unsigned_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        ready_o;
  logic        busy_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        misalign_o;

  int checks = 0;
  int errors = 0;

  data_mem_bytelane #(
    .ADDR_W       (32),
    .DEPTH_WORDS  (16),
    .CLEAR_ON_RST (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .we_i       (we_i),
    .size_i     (size_i),
    .unsigned_i (unsigned_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .ready_o    (ready_o),
    .busy_o     (busy_o),
    .rvalid_o   (rvalid_o),
    .rdata_o    (rdata_o),
    .misalign_o (misalign_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Present one request for one rising edge; returns on the following
  // falling edge, where that request's response is visible.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] d);
    req_i      = 1'b1;
    we_i       = we;
    size_i     = sz;
    unsigned_i = uns;
    addr_i     = a;
    wdata_i    = d;
    @(negedge clk);
    req_i = 1'b0;
  endtask

  task automatic load_chk(input string tag, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] exp);
    issue(1'b0, sz, uns, a, 32'h0);
    chk({tag, "_rvalid"}, 32'(rvalid_o), 32'd1);
    chk(tag, rdata_o, exp);
  endtask

  // Count busy cycles from the current falling edge, bounded.
  task automatic count_sweep(output int n);
    n = 0;
    while (busy_o && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    logic stray;

    rst = 1'b1; req_i = 1'b0; we_i = 1'b0; size_i = W;
    unsigned_i = 1'b0; addr_i = 32'h0; wdata_i = 32'h0;
    repeat (2) @(negedge clk);

    chk("rst_rvalid", 32'(rvalid_o), 32'd0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_misalign", 32'(misalign_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd1);

    // Initial sweep with a reserved-size load held on req: must be ignored.
    rst = 1'b0;
    req_i = 1'b1; we_i = 1'b0; size_i = R; addr_i = 32'h6;
    n = 0; stray = 1'b0;
    while (busy_o && n < 100) begin
      n++;
      if (rvalid_o || misalign_o || ready_o) stray = 1'b1;
      @(negedge clk);
    end
    req_i = 1'b0;
    @(negedge clk);
    chk("sweep_len", 32'(n), 32'd16);
    chk("sweep_ignored_req", 32'(stray), 32'd0);
    chk("ready_after_sweep", 32'(ready_o), 32'd1);
    chk("busy_after_sweep", 32'(busy_o), 32'd0);
    chk("no_late_pulse", 32'(misalign_o), 32'd0);

    load_chk("lw_3c_clear", W, 1'b0, 32'h3C, 32'h0);

    // Byte/half lane writes.
    issue(1'b1, W, 1'b0, 32'h8, 32'h11223344);
    chk("sw_no_rvalid", 32'(rvalid_o), 32'd0);
    chk("sw_no_misalign", 32'(misalign_o), 32'd0);
    issue(1'b1, B, 1'b0, 32'h9, 32'h000000AA);
    issue(1'b1, H, 1'b0, 32'hA, 32'h0000BEEF);
    load_chk("lw_8", W, 1'b0, 32'h8, 32'hBEEFAA44);
    chk("lw_8_misalign", 32'(misalign_o), 32'd0);
    load_chk("lb_9", B, 1'b0, 32'h9, 32'hFFFFFFAA);
    load_chk("lbu_9", B, 1'b1, 32'h9, 32'h000000AA);
    load_chk("lh_a", H, 1'b0, 32'hA, 32'hFFFFBEEF);
    load_chk("lhu_a", H, 1'b1, 32'hA, 32'h0000BEEF);
    load_chk("lhu_8", H, 1'b1, 32'h8, 32'h0000AA44);
    load_chk("lb_8", B, 1'b0, 32'h8, 32'h00000044);
    load_chk("lb_b", B, 1'b0, 32'hB, 32'hFFFFFFBE);

    // Misaligned and reserved accesses.
    issue(1'b1, W, 1'b0, 32'h4, 32'hCAFEF00D);
    issue(1'b1, W, 1'b0, 32'h6, 32'hDEADBEEF);
    chk("sw_mis_pulse", 32'(misalign_o), 32'd1);
    chk("sw_mis_rvalid", 32'(rvalid_o), 32'd0);
    issue(1'b1, H, 1'b0, 32'h5, 32'h00001234);
    chk("sh_mis_pulse", 32'(misalign_o), 32'd1);
    load_chk("lw_4_unchanged", W, 1'b0, 32'h4, 32'hCAFEF00D);
    chk("mis_one_cycle", 32'(misalign_o), 32'd0);
    load_chk("lh_3_mis", H, 1'b0, 32'h3, 32'h0);
    chk("lh_3_mis_pulse", 32'(misalign_o), 32'd1);
    load_chk("rsvd_mis", R, 1'b0, 32'h8, 32'h0);
    chk("rsvd_mis_pulse", 32'(misalign_o), 32'd1);

    // Address wrap modulo 64 bytes.
    issue(1'b1, W, 1'b0, 32'h40, 32'h12345678);
    load_chk("lw_0_wrap", W, 1'b0, 32'h0, 32'h12345678);

    // Store then load back-to-back, then two back-to-back loads.
    issue(1'b1, W, 1'b0, 32'h10, 32'hA5A55A5A);
    load_chk("b2b_st_ld", W, 1'b0, 32'h10, 32'hA5A55A5A);
    load_chk("b2b_ld1", W, 1'b0, 32'h8, 32'hBEEFAA44);
    load_chk("b2b_ld2", W, 1'b0, 32'h4, 32'hCAFEF00D);
    @(negedge clk);
    chk("idle_rvalid", 32'(rvalid_o), 32'd0);
    chk("idle_rdata", rdata_o, 32'h0);

    // Dirty the last word so the second sweep has something to clear.
    issue(1'b1, W, 1'b0, 32'h3C, 32'hFFFFFFFF);
    load_chk("lw_3c_dirty", W, 1'b0, 32'h3C, 32'hFFFFFFFF);

    // Load presented together with reset: discarded.
    rst = 1'b1;
    issue(1'b0, W, 1'b0, 32'h8, 32'h0);
    chk("rst_drop_rvalid", 32'(rvalid_o), 32'd0);
    chk("rst_drop_rdata", rdata_o, 32'h0);
    chk("rst_busy2", 32'(busy_o), 32'd1);

    // Five sweep cycles, then reset again; the sweep must restart in full.
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_sweep_busy", 32'(busy_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    count_sweep(n);
    chk("restart_len", 32'(n), 32'd16);
    chk("restart_ready", 32'(ready_o), 32'd1);

    load_chk("lw_3c_recleared", W, 1'b0, 32'h3C, 32'h0);
    load_chk("lw_8_recleared", W, 1'b0, 32'h8, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_mem_bytelane.md
# data_mem_bytelane

Parametrised word-organised data memory for the MEM stage with byte/half/word access, sign- or zero-extended loads, a registered single-cycle read, and misalignment detection. Reset clears the array with a sequential sweep of one word per cycle instead of a single-cycle clear. The MEM stage drives it with a req/ready handshake and takes load data on `rvalid_o`.

## Interface
- `ADDR_W`, 32: byte-address width.
- `DEPTH_WORDS`, 512: number of 32-bit words; power of two, ≥2.
- `CLEAR_ON_RST`, 1: 1 = zero-fill sweep after reset; 0 = go straight to RUN with contents left unchanged.

- `clk` input 1: rising-edge clock.
- `rst` input 1: synchronous, active-high reset.
- `req_i` input 1: access request; accepted when `req_i && ready_o`.
- `we_i` input 1: 1 = store, 0 = load.
- `size_i` input 2: access size (BYTE/HALF/WORD/RSVD).
- `unsigned_i` input 1: load zero-extends when 1, sign-extends when 0.
- `addr_i` input ADDR_W: byte address.
- `wdata_i` input 32: store data, LSB-aligned (byte in [7:0], half in [15:0]).
- `ready_o` output 1: block can accept a request this cycle.
- `busy_o` output 1: clear sweep in progress.
- `rvalid_o` output 1: one-cycle pulse; `rdata_o` is valid.
- `rdata_o` output 32: extended load data; 0 whenever `rvalid_o`=0.
- `misalign_o` output 1: one-cycle pulse, cycle after acceptance of a misaligned or RSVD access.

## Operation
- Word index = `addr_i[IDX_W+1:2]`, where IDX_W = clog2(DEPTH_WORDS). Upper address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
- Lanes are little-endian. Lane = `addr_i[1:0]`.
- BYTE writes lane `addr[1:0]`. HALF writes lanes {2·addr[1], 2·addr[1]+1}. WORD writes all 4 lanes. Unwritten lanes keep their value.
- Misaligned access: HALF with addr[0]=1, WORD with addr[1:0]≠0, or any RSVD size.
  - Store: no write.
  - Load: `rvalid_o` pulses with `rdata_o`=0.
  - Both: `misalign_o` pulses.
- Load extension: BYTE and HALF take bit 7 or bit 15 as sign, unless `unsigned_i`=1. WORD is passed through unchanged.
- Stores produce no `rvalid_o`.
- FSM states:
  - INIT: `busy_o`=1, `ready_o`=0. Counter clr_idx writes 0 to word clr_idx each cycle. After the last word (DEPTH_WORDS-1) is written, go to RUN.
  - RUN: `ready_o`=1, `busy_o`=0. Stays in RUN until `rst`.
- With `rst`=1: FSM goes to INIT (CLEAR_ON_RST=1) or RUN (CLEAR_ON_RST=0), clr_idx=0, and any pending read result is discarded.
- Requests while `ready_o`=0 are ignored. No queueing, no error.

## Timing
- Reset values (cycle after a `rst` edge): `rvalid_o`=0, `rdata_o`=0, `misalign_o`=0.
  - CLEAR_ON_RST=1: `ready_o`=0, `busy_o`=1.
  - CLEAR_ON_RST=0: `ready_o`=1, `busy_o`=0.
- Sweep length: DEPTH_WORDS cycles, counted from the first edge with `rst`=0. `ready_o` rises in the cycle after the final clear write.
- `rst` asserted mid-sweep restarts the sweep at index 0.
- Load accepted at edge N: `rvalid_o`/`rdata_o` are valid during cycle N+1. This is a registered output.
- Back-to-back loads give one result per cycle.
- Store accepted at edge N updates the array at edge N. A load accepted at edge N+1 to the same word returns the new data.
- The array is single-ported. There are no simultaneous read/write hazards, since only one request is accepted per cycle.
- `misalign_o` has the same latency as `rvalid_o`: cycle N+1.

## Structure
- Package `dmem_pkg`:
  - SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_RSVD=2'b11.
  - FSM encoding ST_INIT/ST_RUN.
  - Function `clog2`.
- Sub-module `dmem_lane_align` (combinational), used for both store and load paths:
  - Store path: from size, addr[1:0] and wdata produce a 4-bit byte strobe, lane-replicated write data, and the misaligned flag.
  - Load path: from the raw word, size, addr[1:0] and `unsigned_i` produce the extended load data.
- Top level holds the array, FSM, clr_idx counter and the output registers. The registered copies of size, addr[1:0] and unsigned feed `dmem_lane_align` in cycle N+1.

## Test plan
- Reset then sweep (DEPTH_WORDS=16, CLEAR_ON_RST=1): `busy_o`=1 for exactly 16 cycles, then `ready_o`=1. A WORD load from 0x3C returns 0x00000000.
- Byte/half stores:
  - SW 0x11223344 to 0x8, then SB 0xAA to 0x9, then SH 0xBEEF to 0xA.
  - LW 0x8 returns 0xBEEFAA44.
  - LB 0x9 returns 0xFFFFFFAA; LBU 0x9 returns 0x000000AA; LH 0xA returns 0xFFFFBEEF.
- Misalignment:
  - SW 0xDEADBEEF to 0x6: `misalign_o` pulses and the word is unchanged.
  - LH 0x3: `rvalid_o`=1, `rdata_o`=0, `misalign_o`=1.
  - size=RSVD gives the same response.
- Wrap (DEPTH_WORDS=16): SW 0x12345678 to 0x40; LW 0x0 returns 0x12345678.
- Store-then-load, back-to-back, same word: the load returns the new data with 1-cycle latency.
- `rst` pulsed at sweep cycle 5: sweep restarts and takes the full 16 cycles. A load in flight at the `rst` edge produces no `rvalid_o`.
